tmem_ctrl: RTL and testbench

Tagged-memory controller between the CPU's multiplexed address/data bus and a synchronous single-port tagged SRAM (64-bit data + 8-bit tag per word). It latches addresses from the address strobe, auto-increments for sequential accesses, and sequences read-modify-write (atomic) cycles. It registers all SRAM commands and returns read data and tags to the CPU with fixed latency. It replaces the behavioural RAM model on the CPU's memory port in synthesizable builds.

---
 rtl/tmem_ctrl.sv | 139 +++++++++++++
 tb/tb_tmem_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmem_ctrl.sv
// Tagged-memory controller: bridges the CPU's multiplexed address/data bus to a single-port
// tagged SRAM, with address latch/auto-increment, atomic RMW sequencing and registered commands.
module tmem_ctrl #(
  parameter int unsigned AW = 20,
  parameter int unsigned DW = 64,
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_ad,
  input  logic [TW-1:0] i_tag,
  input  logic          i_astb,
  input  logic          i_atomic,
  input  logic          i_rd,
  input  logic          i_wr,
  output logic [DW-1:0] o_data,
  output logic [TW-1:0] o_tag,
  output logic          o_lock,
  output logic          o_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [TW-1:0] mem_wtag,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  input  logic [TW-1:0] mem_rtag
);

  typedef enum logic [1:0] {StIdle, StRmwRd, StRmwWr} state_e;

  state_e        state_q, state_d, state_eff;
  logic [AW-1:0] addr_q, addr_d, addr_eff;
  logic          aval_q, aval_d;
  logic          err_q, err_d;
  logic          re_q, re_d, we_q, we_d;
  logic          rd_pend_q;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [TW-1:0] wtag_q, wtag_d;
  logic [DW-1:0] data_q;
  logic [TW-1:0] tag_q;
  logic          lock;
  logic          proto_err;

  assign lock = (state_q != StIdle);

  // Any protocol violation drops the whole cycle: no strobe load, no SRAM command.
  always_comb begin
    proto_err = (i_rd && i_wr) ||
                (i_astb && i_wr) ||
                (i_astb && lock) ||
                ((i_rd || i_wr) && !aval_q && !i_astb) ||
                ((state_q == StRmwRd) && i_wr) ||
                ((state_q == StRmwWr) && i_rd);
  end

  always_comb begin
    addr_eff  = i_astb ? i_ad[AW-1:0] : addr_q;
    state_eff = (i_astb && i_atomic) ? StRmwRd : state_q;
    addr_d    = addr_q;
    aval_d    = aval_q;
    state_d   = state_q;
    err_d     = err_q | proto_err;
    re_d      = 1'b0;
    we_d      = 1'b0;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    wtag_d    = wtag_q;
    if (!proto_err) begin
      if (i_astb) begin
        addr_d  = addr_eff;
        aval_d  = 1'b1;
        state_d = state_eff;
      end
      if (i_rd) begin
        re_d    = 1'b1;
        maddr_d = addr_eff;
        // The atomic read keeps the address for the following write.
        if (state_eff == StRmwRd) begin
          state_d = StRmwWr;
        end else begin
          addr_d = addr_eff + AW'(1);
        end
      end else if (i_wr) begin
        we_d    = 1'b1;
        maddr_d = addr_eff;
        wdata_d = i_ad;
        wtag_d  = i_tag;
        addr_d  = addr_eff + AW'(1);
        if (state_eff == StRmwWr) begin
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      aval_q    <= 1'b0;
      err_q     <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      wtag_q    <= '0;
      data_q    <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      aval_q    <= aval_d;
      err_q     <= err_d;
      re_q      <= re_d;
      we_q      <= we_d;
      rd_pend_q <= re_q;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      wtag_q    <= wtag_d;
      if (rd_pend_q) begin
        data_q <= mem_rdata;
        tag_q  <= mem_rtag;
      end
    end
  end

  assign o_data    = data_q;
  assign o_tag     = tag_q;
  assign o_lock    = lock;
  assign o_err     = err_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign mem_wtag  = wtag_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;

endmodule

// File: tb/tb_tmem_ctrl.sv
// Bench for tmem_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model with its own memory and read queue.
module tb_tmem_ctrl;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i_ad;
  logic [TW-1:0] i_tag;
  logic          i_astb, i_atomic, i_rd, i_wr;
  logic [DW-1:0] o_data;
  logic [TW-1:0] o_tag;
  logic          o_lock, o_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [TW-1:0] mem_wtag;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic [TW-1:0] mem_rtag = '0;

  int checks = 0;
  int failures = 0;

  tmem_ctrl #(.AW(AW), .DW(DW), .TW(TW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_ad     (i_ad),
    .i_tag    (i_tag),
    .i_astb   (i_astb),
    .i_atomic (i_atomic),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .o_data   (o_data),
    .o_tag    (o_tag),
    .o_lock   (o_lock),
    .o_err    (o_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wtag (mem_wtag),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .mem_rtag (mem_rtag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of never-written words, shared by the SRAM stand-in and the model.
  function automatic logic [71:0] init_word(input int a);
    return {8'(a * 7 + 3), 32'hC0DE0000 | 32'(a), 32'(a ^ 32'h5555AAAA)};
  endfunction

  // SRAM stand-in driven purely from the DUT's memory pins.
  logic [71:0] sram [int];
  always @(posedge clk) begin
    if (mem_we) sram[int'(mem_addr)] = {mem_wtag, mem_wdata};
    if (mem_re) begin
      if (sram.exists(int'(mem_addr))) {mem_rtag, mem_rdata} <= sram[int'(mem_addr)];
      else {mem_rtag, mem_rdata} <= init_word(int'(mem_addr));
    end
  end

  // Transaction-level model: memory updated at issue time, reads delivered two edges later.
  typedef struct {
    int          due;
    logic [71:0] w;
  } rd_t;
  rd_t         rq[$];
  logic [71:0] mm [int];
  int          cyc = 0;
  int          m_addr;
  int          m_phase;  // 0 free, 1 awaiting atomic read, 2 awaiting atomic write
  bit          m_aval, m_err, model_ok = 0, bad;
  logic [63:0] e_data, e_wdata;
  logic [7:0]  e_tag, e_wtag;
  logic [19:0] e_addr;
  bit          e_re, e_we;
  rd_t         got;

  function automatic logic [71:0] mm_get(input int a);
    if (mm.exists(a)) return mm[a];
    return init_word(a);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      rq.delete();
      m_addr = 0; m_phase = 0; m_aval = 0; m_err = 0;
      e_data = '0; e_tag = '0; e_wdata = '0; e_wtag = '0; e_addr = '0;
      e_re = 0; e_we = 0;
      model_ok = 1;
    end else if (model_ok) begin
      e_re = 0;
      e_we = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        got = rq.pop_front();
        e_tag = got.w[71:64];
        e_data = got.w[63:0];
      end
      bad = (i_rd && i_wr) || (i_astb && i_wr) || (i_astb && m_phase != 0) ||
            ((i_rd || i_wr) && !m_aval && !i_astb) || (m_phase == 1 && i_wr) ||
            (m_phase == 2 && i_rd);
      if (bad) begin
        m_err = 1;
      end else begin
        if (i_astb) begin
          m_addr = int'(i_ad[19:0]);
          m_aval = 1;
          if (i_atomic) m_phase = 1;
        end
        if (i_rd) begin
          e_re = 1;
          e_addr = 20'(m_addr);
          rq.push_back('{due: cyc + 2, w: mm_get(m_addr)});
          if (m_phase == 1) m_phase = 2;
          else m_addr = (m_addr + 1) % (1 << AW);
        end else if (i_wr) begin
          e_we = 1;
          e_addr = 20'(m_addr);
          e_wdata = i_ad;
          e_wtag = i_tag;
          mm[m_addr] = {i_tag, i_ad};
          if (m_phase == 2) m_phase = 0;
          m_addr = (m_addr + 1) % (1 << AW);
        end
      end
    end
    #1;
    if (model_ok) begin
      chk("o_data", o_data, e_data);
      chk("o_tag", 64'(o_tag), 64'(e_tag));
      chk("o_lock", 64'(o_lock), 64'(m_phase != 0));
      chk("o_err", 64'(o_err), 64'(m_err));
      chk("mem_re", 64'(mem_re), 64'(e_re));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wtag", 64'(mem_wtag), 64'(e_wtag));
    end
  end

  task automatic drive(input bit astb, input bit atomic, input bit rd, input bit wr,
                       input logic [63:0] ad, input logic [7:0] tag);
    i_astb = astb; i_atomic = atomic; i_rd = rd; i_wr = wr; i_ad = ad; i_tag = tag;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 64'h0, 8'h0);
  endtask

  task automatic do_reset();
    reset = 1;
    idle(2);
    reset = 0;
  endtask

  logic [19:0] picks [7] = '{20'h00010, 20'h00011, 20'h00012, 20'hFFFFF, 20'hFFFFE,
                             20'h00000, 20'h00200};

  initial begin
    logic [63:0] ad;
    int op;
    reset = 1;
    i_astb = 0; i_atomic = 0; i_rd = 0; i_wr = 0; i_ad = '0; i_tag = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_o_data", o_data, 64'h0);
    chk("rst_o_lock", 64'(o_lock), 64'h0);
    chk("rst_o_err", 64'(o_err), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_re_we", 64'({mem_re, mem_we}), 64'h0);

    // Read without an address strobe.
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    chk("noaddr_err", 64'(o_err), 64'h1);
    chk("noaddr_re", 64'(mem_re), 64'h0);

    // Write then read back through the SRAM.
    drive(1, 0, 0, 0, 64'h10, 8'h0);
    drive(0, 0, 0, 1, 64'hDEADBEEF_00000001, 8'h5A);
    chk("wr_addr", 64'(mem_addr), 64'h10);
    chk("wr_we", 64'(mem_we), 64'h1);
    drive(1, 0, 0, 0, 64'h10, 8'h0);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    chk("rd_re", 64'(mem_re), 64'h1);
    idle(1);
    chk("rd_lat_early", o_data, 64'h0);
    idle(1);
    chk("rd_data", o_data, 64'hDEADBEEF_00000001);
    chk("rd_tag", 64'(o_tag), 64'h5A);

    // Address wrap on writes and back-to-back reads.
    drive(1, 0, 0, 0, 64'hFFFFF, 8'h0);
    drive(0, 0, 0, 1, 64'h1111_2222_3333_4444, 8'hA1);
    chk("wrap_addr0", 64'(mem_addr), 64'hFFFFF);
    drive(0, 0, 0, 1, 64'h5555_6666_7777_8888, 8'hA2);
    chk("wrap_addr1", 64'(mem_addr), 64'h0);
    drive(1, 0, 0, 0, 64'hFFFFF, 8'h0);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    idle(1);
    chk("b2b_data0", o_data, 64'h1111_2222_3333_4444);
    idle(1);
    chk("b2b_data1", o_data, 64'h5555_6666_7777_8888);

    // Atomic read-modify-write with idle gap.
    drive(1, 1, 0, 0, 64'h200, 8'h0);
    chk("at_lock0", 64'(o_lock), 64'h1);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    chk("at_rd_addr", 64'(mem_addr), 64'h200);
    idle(3);
    chk("at_lock1", 64'(o_lock), 64'h1);
    drive(0, 0, 0, 1, 64'h77, 8'h11);
    chk("at_wr_addr", 64'(mem_addr), 64'h200);
    chk("at_unlock", 64'(o_lock), 64'h0);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    chk("at_next_addr", 64'(mem_addr), 64'h201);

    // Protocol errors during an atomic sequence.
    do_reset();
    drive(1, 1, 0, 0, 64'h200, 8'h0);
    drive(1, 0, 0, 0, 64'h300, 8'h0);
    chk("lk_strobe_err", 64'(o_err), 64'h1);
    drive(0, 0, 0, 1, 64'h99, 8'h0);
    chk("lk_wr_dropped", 64'(mem_we), 64'h0);
    chk("lk_err_sticky", 64'(o_err), 64'h1);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    chk("lk_addr_kept", 64'(mem_addr), 64'h200);
    drive(0, 0, 0, 1, 64'h1234, 8'h22);

    // Reset while an atomic read is in flight.
    do_reset();
    drive(1, 1, 0, 0, 64'h10, 8'h0);
    drive(0, 0, 1, 0, 64'h0, 8'h0);
    reset = 1;
    idle(1);
    reset = 0;
    chk("mr_re", 64'(mem_re), 64'h0);
    chk("mr_lock", 64'(o_lock), 64'h0);
    idle(2);
    chk("mr_data", o_data, 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bit astb, atomic, rd, wr;
        astb = ($urandom_range(0, 3) == 0);
        atomic = astb && ($urandom_range(0, 2) == 0);
        op = $urandom_range(0, 9);
        rd = (op <= 3) || (op == 7);
        wr = (op >= 4 && op <= 7);
        ad = {$urandom, $urandom};
        if (astb || $urandom_range(0, 3) == 0) ad[19:0] = picks[$urandom_range(0, 6)];
        drive(astb, atomic, rd, wr, ad, 8'($urandom));
      end
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
